ppu_mem_arbiter: RTL and testbench
==================================

Name: ppu_mem_arbiter

Overview:
Owns the VRAM (8000-9FFF) and OAM (FE00-FE9F) ports and shares them between the CPU bus, the PPU fetch port and an OAM DMA engine. Sits between the CPU MMIO decode and the PPU. Applies mode-based CPU lockout from the PPU mode output. Runs the FF46 OAM DMA transfer.

Parameters:
DMA_LEN, 160, bytes copied per OAM DMA
DMA_START_DELAY, 1, idle cycles between the FF46 write and the first source read

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
lcd_on  in  1  LCDC[7]; 0 disables all CPU lockout
ppu_mode  in  2  0 HBLANK, 1 VBLANK, 2 SCAN, 3 DRAW
cpu_addr  in  16  CPU address
cpu_rd  in  1  CPU read strobe
cpu_wr  in  1  CPU write strobe
cpu_wdata  in  8  CPU write data
cpu_rdata  out  8  CPU read data, valid 1 cycle after cpu_rd
ppu_addr  in  16  PPU fetch address
ppu_rd  in  1  PPU read strobe
ppu_rdata  out  8  PPU read data, valid 1 cycle after ppu_rd
vram_addr  out  13  VRAM offset
vram_rd  out  1  VRAM read strobe
vram_wr  out  1  VRAM write strobe
vram_wdata  out  8  VRAM write data
vram_rdata  in  8  VRAM read data (1-cycle latency)
oam_addr  out  8  OAM offset
oam_rd  out  1  OAM read strobe
oam_wr  out  1  OAM write strobe
oam_wdata  out  8  OAM write data
oam_rdata  in  8  OAM read data (1-cycle latency)
sys_addr  out  16  DMA source address
sys_rd  out  1  DMA source read strobe
sys_rdata  in  8  DMA source data (1-cycle latency)
dma_active  out  1  DMA in progress

Behaviour:
- Reset: all strobes 0, addresses 0, dma_active 0, cpu_rdata and ppu_rdata 8'hFF, DMA FSM in IDLE. Reset mid-DMA aborts the transfer immediately; OAM keeps the bytes already written.
- Lock conditions:
  - vram_lock = lcd_on && ppu_mode==3.
  - oam_lock = (lcd_on && ppu_mode in {2,3}) || dma_active.
- Port ownership, decided combinationally each cycle:
  - VRAM port: PPU if ppu_rd && ppu_addr in VRAM. Otherwise CPU if the CPU accesses VRAM and !vram_lock. Otherwise idle.
  - OAM port: DMA if dma_active. Otherwise PPU if ppu_rd && ppu_addr in OAM. Otherwise CPU if the CPU accesses OAM and !oam_lock. Otherwise idle.
  - PPU beats CPU even when unlocked. The losing CPU access is treated as blocked.
- Blocked CPU access: write dropped; the read returns 8'hFF on the next cycle. Same rule for a CPU access to FEA0-FEFF.
- Blocked PPU OAM read (during DMA): returns 8'hFF.
- Read data: a 1-cycle registered source tag (VRAM / OAM / FF) per requester selects rdata. This gives 1-cycle latency matching the RAMs. Non-VRAM/OAM CPU addresses return 8'hFF from this block, except FF46.
- FF46: a write latches src_hi. A read of FF46 returns src_hi.
- DMA FSM:
  - IDLE: a CPU write to FF46 sets idx=0 -> DELAY.
  - DELAY: waits DMA_START_DELAY cycles with dma_active=1 -> XFER.
  - XFER, each cycle:
    - if idx<DMA_LEN: issue sys_rd with sys_addr={src_hi,idx[7:0]};
    - if idx>0: write oam_addr=idx-1, oam_wdata=sys_rdata;
    - idx++.
    - When idx==DMA_LEN (write of byte 159 issued), go to IDLE the next cycle and drop dma_active.
- Total for DMA_LEN=160: dma_active high for 1+161 cycles.
- A FF46 write during DMA restarts: new src_hi, idx=0, DELAY. The in-flight write still completes.
- An FF46 write with lcd_on=0 behaves identically; DMA ignores lcd_on.
- Simultaneous cpu_rd and cpu_wr: the write wins, and no rdata update is required.

Optional Feature:
OAM_DMA_EN. Defined: DMA FSM, FF46 latch and sys_* port exist as specified. Undefined: FF46 writes are ignored and FF46 reads return 8'hFF. dma_active, sys_rd, sys_addr are tied to 0. oam_lock reduces to its mode term.

Test Plan:
- lcd_on=1, mode=3, CPU writes 8000<=8'h5A -> vram_wr stays 0; CPU read 8000 returns 8'hFF one cycle later.
- lcd_on=1, mode=0, CPU writes 8000<=8'h5A then reads it -> vram_wr=1, vram_addr=0; read returns 8'h5A (memory model).
- mode=2, CPU read FE00 -> 8'hFF. Same cycle, ppu_rd FE04 -> oam_addr=4, ppu_rdata=OAM[4].
- CPU writes FF46<=8'hC1 (source C100-C19F = 0..159) -> dma_active high 162 cycles; OAM[i]==i for all i; CPU OAM reads during DMA return 8'hFF.
- At idx=80, CPU writes FF46<=8'hC2 -> restart from C200; final OAM matches the C2xx data.
- Assert rst at idx=50 -> dma_active=0 next cycle; no further oam_wr.

Source files
------------

// File: rtl/ppu_mem_arbiter.sv
// ppu_mem_arbiter: shares VRAM/OAM between CPU, PPU fetch and OAM DMA with PPU-mode lockout.
// Define OAM_DMA_EN to build the FF46 OAM DMA engine; without it FF46 is inert.
module ppu_mem_arbiter #(
  parameter int DMA_LEN         = 160,
  parameter int DMA_START_DELAY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        lcd_on,
  input  logic [1:0]  ppu_mode,
  input  logic [15:0] cpu_addr,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_wdata,
  output logic [7:0]  cpu_rdata,
  input  logic [15:0] ppu_addr,
  input  logic        ppu_rd,
  output logic [7:0]  ppu_rdata,
  output logic [12:0] vram_addr,
  output logic        vram_rd,
  output logic        vram_wr,
  output logic [7:0]  vram_wdata,
  input  logic [7:0]  vram_rdata,
  output logic [7:0]  oam_addr,
  output logic        oam_rd,
  output logic        oam_wr,
  output logic [7:0]  oam_wdata,
  input  logic [7:0]  oam_rdata,
  output logic [15:0] sys_addr,
  output logic        sys_rd,
  input  logic [7:0]  sys_rdata,
  output logic        dma_active
);
  typedef enum logic [1:0] {SRC_BYTE, SRC_VRAM, SRC_OAM} src_t;
  logic cpu_acc, cpu_rd_only, cpu_in_vram, cpu_in_oam, ppu_in_vram, ppu_in_oam, ff46_wr;
  logic vram_lock, oam_lock, ppu_vram, ppu_oam, cpu_vram, cpu_oam, dma_wr;
  logic [7:0] dma_oam_addr, ff46_byte, cpu_byte;
  src_t cpu_src, ppu_src;

  always_comb begin
    cpu_acc     = cpu_rd | cpu_wr;
    cpu_rd_only = cpu_rd & ~cpu_wr;
    cpu_in_vram = cpu_addr[15:13] == 3'b100;
    cpu_in_oam  = cpu_addr[15:8] == 8'hFE && cpu_addr[7:0] < 8'hA0;
    ppu_in_vram = ppu_addr[15:13] == 3'b100;
    ppu_in_oam  = ppu_addr[15:8] == 8'hFE && ppu_addr[7:0] < 8'hA0;
    ff46_wr     = cpu_wr && cpu_addr == 16'hFF46;
    vram_lock   = lcd_on && ppu_mode == 2'd3;
    oam_lock    = (lcd_on && ppu_mode[1]) || dma_active;
    ppu_vram    = ppu_rd && ppu_in_vram;
    ppu_oam     = ppu_rd && ppu_in_oam && !dma_active;
    cpu_vram    = cpu_acc && cpu_in_vram && !vram_lock && !ppu_vram;
    cpu_oam     = cpu_acc && cpu_in_oam && !oam_lock && !ppu_oam;
  end

  always_comb begin
    vram_rd    = !rst && (ppu_vram || (cpu_vram && cpu_rd_only));
    vram_wr    = !rst && cpu_vram && cpu_wr;
    vram_addr  = rst ? 13'h0 : ppu_vram ? ppu_addr[12:0] : cpu_vram ? cpu_addr[12:0] : 13'h0;
    vram_wdata = vram_wr ? cpu_wdata : 8'h0;
    oam_rd     = !rst && (ppu_oam || (cpu_oam && cpu_rd_only));
    oam_wr     = dma_wr || (!rst && cpu_oam && cpu_wr);
    oam_addr   = rst ? 8'h0 : dma_wr ? dma_oam_addr : ppu_oam ? ppu_addr[7:0] : cpu_oam ? cpu_addr[7:0] : 8'h0;
    oam_wdata  = dma_wr ? sys_rdata : oam_wr ? cpu_wdata : 8'h0;
  end

  // Per-requester source tag lines rdata up with the 1-cycle RAM latency.
  always_ff @(posedge clk)
    if (rst) begin
      cpu_src  <= SRC_BYTE;
      ppu_src  <= SRC_BYTE;
      cpu_byte <= 8'hFF;
    end else begin
      cpu_src  <= !cpu_rd_only ? SRC_BYTE : cpu_vram ? SRC_VRAM : cpu_oam ? SRC_OAM : SRC_BYTE;
      ppu_src  <= ppu_vram ? SRC_VRAM : ppu_oam ? SRC_OAM : SRC_BYTE;
      cpu_byte <= (cpu_rd_only && cpu_addr == 16'hFF46) ? ff46_byte : 8'hFF;
    end

  always_comb begin
    cpu_rdata = cpu_src == SRC_VRAM ? vram_rdata : cpu_src == SRC_OAM ? oam_rdata : cpu_byte;
    ppu_rdata = ppu_src == SRC_VRAM ? vram_rdata : ppu_src == SRC_OAM ? oam_rdata : 8'hFF;
  end

`ifdef OAM_DMA_EN
  typedef enum logic [1:0] {IDLE, DELAY, XFER} dma_state_t;
  localparam logic [8:0] LEN  = 9'(DMA_LEN);
  localparam logic [7:0] WAIT = 8'(DMA_START_DELAY - 1);
  dma_state_t state, state_nx;
  logic [8:0] idx;
  logic [7:0] dcnt, src_hi;

  always_ff @(posedge clk)
    if (rst) begin
      state  <= IDLE;
      idx    <= 9'd0;
      dcnt   <= 8'd0;
      src_hi <= 8'h0;
    end else begin
      state  <= state_nx;
      idx    <= (state == XFER && !ff46_wr) ? idx + 9'd1 : 9'd0;
      dcnt   <= (state == DELAY && !ff46_wr) ? dcnt + 8'd1 : 8'd0;
      if (ff46_wr) src_hi <= cpu_wdata;
    end

  // A write to FF46 restarts from any state; the write issued this cycle still lands.
  always_comb
    state_nx = ff46_wr ? DELAY
             : (state == DELAY && dcnt == WAIT) ? XFER
             : (state == XFER && idx == LEN) ? IDLE : state;

  always_comb begin
    dma_active   = state != IDLE;
    sys_rd       = !rst && state == XFER && idx < LEN;
    sys_addr     = sys_rd ? {src_hi, idx[7:0]} : 16'h0;
    dma_wr       = !rst && state == XFER && idx != 9'd0;
    dma_oam_addr = idx[7:0] - 8'd1;
    ff46_byte    = src_hi;
  end
`else
  logic unused_cfg;
  always_comb begin
    dma_active   = 1'b0;
    sys_rd       = 1'b0;
    sys_addr     = 16'h0;
    dma_wr       = 1'b0;
    dma_oam_addr = 8'h0;
    ff46_byte    = 8'hFF;
  end
  assign unused_cfg = ^{ff46_wr, 8'(DMA_LEN), 8'(DMA_START_DELAY)};
`endif
endmodule

// File: tb/tb_ppu_mem_arbiter.sv
// tb_ppu_mem_arbiter: randomized + directed scoreboard bench for ppu_mem_arbiter with bench-side RAMs.
module tb_ppu_mem_arbiter;
  localparam int LEN  = 160;
  localparam int BUSY = 1 + LEN + 1;
`ifdef OAM_DMA_EN
  localparam bit DMA_EN = 1'b1;
`else
  localparam bit DMA_EN = 1'b0;
`endif
  logic clk = 0, rst = 1, lcd_on = 0, cpu_rd = 0, cpu_wr = 0, ppu_rd = 0;
  logic [1:0] ppu_mode = 0;
  logic [15:0] cpu_addr = 0, ppu_addr = 0, sys_addr;
  logic [7:0] cpu_wdata = 0, cpu_rdata, ppu_rdata, vram_wdata, oam_wdata, oam_addr;
  logic [7:0] vram_rdata = 0, oam_rdata = 0, sys_rdata = 0;
  logic [12:0] vram_addr;
  logic vram_rd, vram_wr, oam_rd, oam_wr, sys_rd, dma_active;
  logic [7:0] vram_mem [8192], oam_mem [256], ref_vram [8192], ref_oam [256];
  logic [7:0] cpu_q [$], ppu_q [$];
  logic [7:0] src_hi = 0, dma_src = 0;
  logic c_rd_q = 0, p_rd_q = 0;
  int dma_left = 0, act_cycles = 0, errors = 0, checks = 0;

  always #5 clk = ~clk;

  ppu_mem_arbiter dut (
    .clk(clk), .rst(rst), .lcd_on(lcd_on), .ppu_mode(ppu_mode),
    .cpu_addr(cpu_addr), .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_rdata(cpu_rdata),
    .ppu_addr(ppu_addr), .ppu_rd(ppu_rd), .ppu_rdata(ppu_rdata),
    .vram_addr(vram_addr), .vram_rd(vram_rd), .vram_wr(vram_wr), .vram_wdata(vram_wdata), .vram_rdata(vram_rdata),
    .oam_addr(oam_addr), .oam_rd(oam_rd), .oam_wr(oam_wr), .oam_wdata(oam_wdata), .oam_rdata(oam_rdata),
    .sys_addr(sys_addr), .sys_rd(sys_rd), .sys_rdata(sys_rdata), .dma_active(dma_active)
  );

  function automatic logic [7:0] sys_byte(input logic [15:0] a);
    logic [7:0] hi;
    hi = a[15:8] - 8'hC1;
    return a[7:0] + {hi[3:0], 4'h0};
  endfunction

  function automatic logic in_vram(input logic [15:0] a);
    return a >= 16'h8000 && a <= 16'h9FFF;
  endfunction

  function automatic logic in_oam(input logic [15:0] a);
    return a >= 16'hFE00 && a < 16'hFEA0;
  endfunction

  always @(posedge clk) begin
    if (vram_rd) vram_rdata <= vram_mem[vram_addr];
    if (vram_wr) vram_mem[vram_addr] = vram_wdata;
    if (oam_rd) oam_rdata <= oam_mem[oam_addr];
    if (oam_wr) oam_mem[oam_addr] = oam_wdata;
    if (sys_rd) sys_rdata <= sys_byte(sys_addr);
    c_rd_q <= cpu_rd && !cpu_wr && !rst;
    p_rd_q <= ppu_rd && !rst;
  end

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard one cycle after each read strobe.
  always @(negedge clk) begin
    if (dma_active) act_cycles++;
    if (c_rd_q) begin
      if (cpu_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL cpu_q_underflow: got rdata %0h with no expected entry", cpu_rdata);
      end else chk("cpu_rdata", cpu_rdata, cpu_q.pop_front());
    end
    if (p_rd_q) begin
      if (ppu_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL ppu_q_underflow: got rdata %0h with no expected entry", ppu_rdata);
      end else chk("ppu_rdata", ppu_rdata, ppu_q.pop_front());
    end
  end

  task automatic step(input logic rd, input logic wr, input logic [15:0] a, input logic [7:0] d,
                      input logic prd, input logic [15:0] pa);
    logic busy, v_lock, o_lock, p_v, p_o, c_v, c_o;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = a; cpu_wdata = d; ppu_rd = prd; ppu_addr = pa;
    busy   = dma_left > 0;
    v_lock = lcd_on && ppu_mode == 2'd3;
    o_lock = (lcd_on && ppu_mode >= 2'd2) || busy;
    p_v    = prd && in_vram(pa);
    p_o    = prd && in_oam(pa) && !busy;
    c_v    = (rd || wr) && in_vram(a) && !v_lock && !p_v;
    c_o    = (rd || wr) && in_oam(a) && !o_lock && !p_o;
    if (rd && !wr)
      cpu_q.push_back(c_v ? ref_vram[a[12:0]] : c_o ? ref_oam[a[7:0]] : (DMA_EN && a == 16'hFF46) ? src_hi : 8'hFF);
    if (prd) ppu_q.push_back(p_v ? ref_vram[pa[12:0]] : p_o ? ref_oam[pa[7:0]] : 8'hFF);
    @(negedge clk);
    chk("dma_active", dma_active, busy);
    chk("vram_wr", vram_wr, wr && c_v);
    chk("oam_wr", oam_wr, busy ? dma_left <= LEN : wr && c_o);
    if (p_v || c_v) chk("vram_addr", vram_addr, p_v ? pa[12:0] : a[12:0]);
    if (p_o || c_o) chk("oam_addr", oam_addr, p_o ? pa[7:0] : a[7:0]);
    if (busy && dma_left <= LEN) chk("dma_oam_addr", oam_addr, 16'(LEN - dma_left));
    @(posedge clk); #1;
    if (wr && c_v) ref_vram[a[12:0]] = d;
    if (wr && c_o) ref_oam[a[7:0]] = d;
    if (busy) begin
      dma_left--;
      if (dma_left == 0) for (int i = 0; i < LEN; i++) ref_oam[i] = sys_byte({dma_src, 8'(i)});
    end
    if (DMA_EN && wr && a == 16'hFF46) begin
      src_hi = d; dma_src = d; dma_left = BUSY;
    end
  endtask

  task automatic idle();
    step(0, 0, 16'h0, 8'h0, 0, 16'h0);
  endtask

  task automatic readback();
    lcd_on = 0;
    for (int i = 0; i < LEN; i++) step(1, 0, 16'hFE00 + 16'(i), 8'h0, 0, 16'h0);
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) begin vram_mem[i] = 8'(i) ^ 8'hA5; ref_vram[i] = vram_mem[i]; end
    for (int i = 0; i < 256; i++) begin oam_mem[i] = 8'(i * 3) ^ 8'h5C; ref_oam[i] = oam_mem[i]; end
    cpu_wr = 1; cpu_addr = 16'h8000; cpu_wdata = 8'h77; ppu_rd = 1; ppu_addr = 16'hFE04;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
    chk("rst_ppu_rdata", ppu_rdata, 8'hFF);
    chk("rst_strobes", {vram_rd, vram_wr, oam_rd, oam_wr, sys_rd, dma_active}, 6'b0);
    chk("rst_vram_addr", vram_addr, 13'h0);
    chk("rst_oam_addr", oam_addr, 8'h0);
    @(posedge clk); #1;
    rst = 0;
    lcd_on = 1; ppu_mode = 3;
    step(0, 1, 16'h8000, 8'h5A, 0, 16'h0);
    step(1, 0, 16'h8000, 8'h0, 0, 16'h0);
    ppu_mode = 0;
    step(0, 1, 16'h8000, 8'h5A, 0, 16'h0);
    step(1, 0, 16'h8000, 8'h0, 0, 16'h0);
    step(0, 1, 16'h8001, 8'h42, 1, 16'h8010);
    step(1, 0, 16'h8001, 8'h0, 0, 16'h0);
    ppu_mode = 2;
    step(1, 0, 16'hFE00, 8'h0, 1, 16'hFE04);
    ppu_mode = 0;
    step(0, 1, 16'hFE10, 8'h3C, 0, 16'h0);
    step(1, 0, 16'hFE10, 8'h0, 0, 16'h0);
    step(0, 1, 16'hFEA5, 8'h11, 0, 16'h0);
    step(1, 0, 16'hFEA5, 8'h0, 0, 16'h0);
    step(1, 1, 16'h8002, 8'h99, 0, 16'h0);
    step(1, 0, 16'h8002, 8'h0, 0, 16'h0);
    step(1, 0, 16'hC000, 8'h0, 0, 16'h0);
    for (int n = 0; n < 600; n++) begin
      logic [15:0] a, pa;
      int k, r;
      lcd_on = 1'($urandom_range(0, 1));
      ppu_mode = 2'($urandom_range(0, 3));
      k = $urandom_range(0, 3);
      a = k == 0 ? 16'h8000 + 16'($urandom_range(0, 15)) + ($urandom_range(0, 1) ? 16'h1FF0 : 16'h0)
        : k == 1 ? 16'hFE00 + 16'($urandom_range(0, 159))
        : k == 2 ? 16'hFEA0 + 16'($urandom_range(0, 95))
        : 16'hC000 + 16'($urandom_range(0, 255));
      pa = $urandom_range(0, 1) ? 16'h8000 + 16'($urandom_range(0, 15)) : 16'hFE00 + 16'($urandom_range(0, 159));
      r = $urandom_range(0, 9);
      step(r < 4 || r == 8, r >= 4 && r <= 8, a, 8'($urandom), $urandom_range(0, 2) == 0, pa);
    end
`ifdef OAM_DMA_EN
    lcd_on = 0; ppu_mode = 0; act_cycles = 0;
    step(0, 1, 16'hFF46, 8'hC1, 0, 16'h0);
    for (int i = 0; i < BUSY + 2; i++)
      step(i % 20 == 5, 0, 16'hFE00 + 16'(i % LEN), 8'h0, i % 7 == 3, 16'hFE08);
    chk("dma_cycles", 16'(act_cycles), 16'(BUSY));
    readback();
    step(0, 1, 16'hFF46, 8'hC1, 0, 16'h0);
    repeat (81) idle();
    step(0, 1, 16'hFF46, 8'hC2, 0, 16'h0);
    repeat (BUSY) idle();
    step(1, 0, 16'hFF46, 8'h0, 0, 16'h0);
    readback();
    step(0, 1, 16'hFF46, 8'hC3, 0, 16'h0);
    repeat (51) idle();
    rst = 1; cpu_rd = 0; cpu_wr = 0; ppu_rd = 0;
    @(negedge clk);
    chk("rst_abort_oam_wr", oam_wr, 1'b0);
    @(posedge clk); #1;
    rst = 0;
    for (int i = 0; i < 49; i++) ref_oam[i] = sys_byte({8'hC3, 8'(i)});
    dma_left = 0;
    repeat (4) idle();
    readback();
`else
    lcd_on = 0;
    step(0, 1, 16'hFF46, 8'hC1, 0, 16'h0);
    repeat (3) idle();
    step(1, 0, 16'hFF46, 8'h0, 0, 16'h0);
    readback();
`endif
    repeat (3) idle();
    chk("cpu_q_empty", 16'(cpu_q.size()), 16'h0);
    chk("ppu_q_empty", 16'(ppu_q.size()), 16'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
